// File: rtl/midi_msg_parser_pkg.sv
// Shared MIDI constants, status nibbles and parser state encoding.
// Imported by the status-length lookup and the message parser.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CH_AT    = 4'hD;
    localparam logic [3:0] PITCH    = 4'hE;

    localparam logic [7:0] RT_MIN   = 8'hF8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SKIP    = 2'd3
    } state_t;

endpackage

// File: rtl/midi_msg_parser_if.sv
// Byte stream in from the MIDI receiver, note events out to the allocator.
// PITCH_BEND_EN adds the pitch-bend value and its valid pulse.
interface midi_msg_parser_if #(
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] data_rx;
    logic              is_command;
    logic              new_byte_strobe;
    logic              note_on;
    logic              note_off;
    logic [3:0]        channel;
    logic [6:0]        note_num;
    logic [6:0]        velocity;
`ifdef PITCH_BEND_EN
    logic [13:0]       pitch_bend;
    logic              pitch_bend_valid;

    modport master (
        output data_rx, is_command, new_byte_strobe,
        input  note_on, note_off, channel, note_num, velocity,
        input  pitch_bend, pitch_bend_valid
    );

    modport slave (
        input  data_rx, is_command, new_byte_strobe,
        output note_on, note_off, channel, note_num, velocity,
        output pitch_bend, pitch_bend_valid
    );
`else
    modport master (
        output data_rx, is_command, new_byte_strobe,
        input  note_on, note_off, channel, note_num, velocity
    );

    modport slave (
        input  data_rx, is_command, new_byte_strobe,
        output note_on, note_off, channel, note_num, velocity
    );
`endif
endinterface

// File: rtl/midi_msg_parser_status_len.sv
// Status byte -> number of data bytes (0/1/2) and system-common skip flag.
// Purely combinational; real-time bytes report length 0, no skip.
module midi_status_len
    import midi_pkg::*;
(
    input  logic [7:0] status_i,
    output logic [1:0] len_o,
    output logic       skip_o
);

    // Decode the high nibble into message length / skip request
    always_comb begin
        len_o  = 2'd0;
        skip_o = 1'b0;
        unique case (1'b1)
            !status_i[7]: ;
            status_i[7:4] == 4'hF: skip_o = (status_i < RT_MIN);
            status_i[7:4] == PROG,
            status_i[7:4] == CH_AT: len_o = 2'd1;
            default: len_o = 2'd2;
        endcase
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice parser with running status; emits note on/off pulses.
// Define PITCH_BEND_EN to also emit pitch-bend values.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter logic [3:0] RX_CHANNEL = 4'd0,
    parameter bit         OMNI       = 1'b1,
    parameter int         BYTE_W     = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    midi_msg_parser_if.slave   bus
);

    state_t     state_q, state_d;
    logic [7:0] status_q, status_d;
    logic [1:0] len_q, len_d;
    logic [6:0] d1_q, d1_d;
    logic       strobe_q;

    logic       note_on_q, note_off_q;
    logic [3:0] channel_q;
    logic [6:0] note_num_q, velocity_q;

    logic [7:0] byte_in;
    logic [6:0] d2;
    logic       accept, is_rt, is_stat, is_data;
    logic [1:0] st_len;
    logic       st_skip;
    logic       done;
    logic       ch_ok;
    logic       on_d, off_d;

    assign byte_in = bus.data_rx[7:0];
    assign d2      = byte_in[6:0];
    assign accept  = bus.new_byte_strobe & ~strobe_q;
    assign is_rt   = bus.is_command & (byte_in >= RT_MIN);
    assign is_stat = accept & bus.is_command & ~is_rt;
    assign is_data = accept & ~bus.is_command;

    midi_status_len u_len (
        .status_i (byte_in),
        .len_o    (st_len),
        .skip_o   (st_skip)
    );

    // Message assembly: status handling, data byte latching, completion
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        len_d    = len_q;
        d1_d     = d1_q;
        done     = 1'b0;
        if (is_stat) begin
            if (st_skip) begin
                state_d  = SKIP;
                status_d = 8'h00;
                len_d    = 2'd0;
            end else begin
                state_d  = WAIT_D1;
                status_d = byte_in;
                len_d    = st_len;
            end
        end else if (is_data) begin
            unique case (state_q)
                WAIT_D1: begin
                    d1_d = d2;
                    if (len_q == 2'd1) begin
                        done = 1'b1;
                    end else begin
                        state_d = WAIT_D2;
                    end
                end
                WAIT_D2: begin
                    done    = 1'b1;
                    state_d = WAIT_D1;
                end
                default: ;
            endcase
        end
    end

    // Event decode on completion; only 2-byte types ever produce events
    always_comb begin
        ch_ok = OMNI || (status_q[3:0] == RX_CHANNEL);
        on_d  = done & ch_ok & (status_q[7:4] == NOTE_ON) & (d2 != 7'd0);
        off_d = done & ch_ok &
                ((status_q[7:4] == NOTE_OFF) |
                 ((status_q[7:4] == NOTE_ON) & (d2 == 7'd0)));
    end

    // Parser state, running status and strobe edge history
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            status_q <= 8'h00;
            len_q    <= 2'd0;
            d1_q     <= 7'd0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            len_q    <= len_d;
            d1_q     <= d1_d;
            strobe_q <= bus.new_byte_strobe;
        end
    end

    // Registered note events; data fields hold until the next event
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            channel_q  <= 4'd0;
            note_num_q <= 7'd0;
            velocity_q <= 7'd0;
        end else begin
            note_on_q  <= on_d;
            note_off_q <= off_d;
            if (on_d | off_d) begin
                channel_q  <= status_q[3:0];
                note_num_q <= d1_q;
                velocity_q <= d2;
            end
        end
    end

    assign bus.note_on  = note_on_q;
    assign bus.note_off = note_off_q;
    assign bus.channel  = channel_q;
    assign bus.note_num = note_num_q;
    assign bus.velocity = velocity_q;

`ifdef PITCH_BEND_EN
    logic        pb_d;
    logic        pb_valid_q;
    logic [13:0] pb_q;

    assign pb_d = done & ch_ok & (status_q[7:4] == PITCH);

    // Pitch bend value {d2,d1}, centred at reset
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pb_valid_q <= 1'b0;
            pb_q       <= 14'h2000;
        end else begin
            pb_valid_q <= pb_d;
            if (pb_d) begin
                pb_q <= {d2, d1_q};
            end
        end
    end

    assign bus.pitch_bend       = pb_q;
    assign bus.pitch_bend_valid = pb_valid_q;
`endif

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: an omni instance and a
// channel-1-only instance fed the same byte stream.
module tb_midi_msg_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    midi_msg_parser_if #(.BYTE_W(8)) m ();
    midi_msg_parser_if #(.BYTE_W(8)) f ();

    midi_msg_parser #(.RX_CHANNEL(4'd0), .OMNI(1'b1), .BYTE_W(8)) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (m)
    );

    midi_msg_parser #(.RX_CHANNEL(4'd1), .OMNI(1'b0), .BYTE_W(8)) dut_f (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (f)
    );

    int checks = 0;
    int errors = 0;

    int on_cnt = 0, off_cnt = 0, fon_cnt = 0, foff_cnt = 0;
    logic [3:0] on_ch, off_ch, fon_ch;
    logic [6:0] on_nn, on_vel, off_nn, off_vel;
`ifdef PITCH_BEND_EN
    int pb_cnt = 0;
    logic [13:0] pb_val;
`endif

    // Count every cycle a pulse is high, so a stretched pulse is caught
    always @(negedge clk) begin
        if (m.note_on) begin
            on_cnt++;
            on_ch = m.channel; on_nn = m.note_num; on_vel = m.velocity;
        end
        if (m.note_off) begin
            off_cnt++;
            off_ch = m.channel; off_nn = m.note_num; off_vel = m.velocity;
        end
        if (f.note_on) begin
            fon_cnt++;
            fon_ch = f.channel;
        end
        if (f.note_off) foff_cnt++;
`ifdef PITCH_BEND_EN
        if (m.pitch_bend_valid) begin
            pb_cnt++;
            pb_val = m.pitch_bend;
        end
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        on_cnt = 0; off_cnt = 0; fon_cnt = 0; foff_cnt = 0;
`ifdef PITCH_BEND_EN
        pb_cnt = 0;
`endif
    endtask

    task automatic send(input logic [7:0] b, input int w);
        @(negedge clk);
        m.data_rx = b; m.is_command = b[7]; m.new_byte_strobe = 1'b1;
        f.data_rx = b; f.is_command = b[7]; f.new_byte_strobe = 1'b1;
        repeat (w - 1) @(negedge clk);
        @(negedge clk);
        m.new_byte_strobe = 1'b0;
        f.new_byte_strobe = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        m.data_rx = 8'h00; m.is_command = 1'b0; m.new_byte_strobe = 1'b0;
        f.data_rx = 8'h00; f.is_command = 1'b0; f.new_byte_strobe = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_note_on", {31'd0, m.note_on}, 32'd0);
        chk("rst_note_off", {31'd0, m.note_off}, 32'd0);
        chk("rst_channel", {28'd0, m.channel}, 32'd0);
        chk("rst_note_num", {25'd0, m.note_num}, 32'd0);
        chk("rst_velocity", {25'd0, m.velocity}, 32'd0);
`ifdef PITCH_BEND_EN
        chk("rst_pitch_bend", {18'd0, m.pitch_bend}, 32'h2000);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 90 3C 64: basic note on
        clr();
        send(8'h90, 1); send(8'h3C, 1); send(8'h64, 1); settle();
        chk("t1_on_cnt", on_cnt, 1);
        chk("t1_off_cnt", off_cnt, 0);
        chk("t1_ch", {28'd0, on_ch}, 32'h0);
        chk("t1_note", {25'd0, on_nn}, 32'h3C);
        chk("t1_vel", {25'd0, on_vel}, 32'h64);
        chk("t1_filt_none", fon_cnt + foff_cnt, 0);

        // 93 40 50 40 00: running status, vel 0 note on = note off
        clr();
        send(8'h93, 1); send(8'h40, 1); send(8'h50, 1);
        send(8'h40, 1); send(8'h00, 1); settle();
        chk("t2_on_cnt", on_cnt, 1);
        chk("t2_off_cnt", off_cnt, 1);
        chk("t2_on_evt", {on_ch, 1'b0, on_nn, 1'b0, on_vel}, {4'h3, 8'h40, 8'h50});
        chk("t2_off_evt", {off_ch, 1'b0, off_nn, 1'b0, off_vel}, {4'h3, 8'h40, 8'h00});
        repeat (5) @(negedge clk);
        chk("t2_hold_ch", {28'd0, m.channel}, 32'h3);
        chk("t2_hold_note", {25'd0, m.note_num}, 32'h40);

        // 90 3C F8 64: real-time byte transparent
        clr();
        send(8'h90, 1); send(8'h3C, 1); send(8'hF8, 1); send(8'h64, 1);
        settle();
        chk("t3_on_cnt", on_cnt, 1);
        chk("t3_note", {25'd0, on_nn}, 32'h3C);
        chk("t3_vel", {25'd0, on_vel}, 32'h64);

        // 80 30 10 with strobe held 3 cycles per byte
        clr();
        send(8'h80, 3); send(8'h30, 3); send(8'h10, 3); settle();
        chk("t4_off_cnt", off_cnt, 1);
        chk("t4_on_cnt", on_cnt, 0);
        chk("t4_evt", {off_ch, 1'b0, off_nn, 1'b0, off_vel}, {4'h0, 8'h30, 8'h10});

        // 91 3C 64: accepted by the channel-1 instance
        clr();
        send(8'h91, 1); send(8'h3C, 1); send(8'h64, 1); settle();
        chk("t5_filt_on", fon_cnt, 1);
        chk("t5_filt_ch", {28'd0, fon_ch}, 32'h1);
        chk("t5_omni_on", on_cnt, 1);
        chk("t5_omni_ch", {28'd0, on_ch}, 32'h1);

        // 90 3C 80 30 10: new status abandons the partial note on
        clr();
        send(8'h90, 1); send(8'h3C, 1);
        send(8'h80, 1); send(8'h30, 1); send(8'h10, 1); settle();
        chk("t6_on_cnt", on_cnt, 0);
        chk("t6_off_cnt", off_cnt, 1);
        chk("t6_off_note", {25'd0, off_nn}, 32'h30);

        // SysEx then data bytes, then a CC, then program change
        clr();
        send(8'hF0, 1); send(8'h7E, 1); send(8'h01, 1); send(8'hF7, 1);
        send(8'h3C, 1); send(8'h64, 1);
        send(8'hB0, 1); send(8'h07, 1); send(8'h7F, 1);
        send(8'hC0, 1); send(8'h05, 1); settle();
        chk("t7_no_events", on_cnt + off_cnt, 0);
        chk("t7_filt_none", fon_cnt + foff_cnt, 0);
        chk("t7_hold_note", {25'd0, m.note_num}, 32'h30);

`ifdef PITCH_BEND_EN
        clr();
        send(8'hE0, 1); send(8'h7F, 1); send(8'h7F, 1); settle();
        chk("pb_cnt", pb_cnt, 1);
        chk("pb_val", {18'd0, pb_val}, 32'h3FFF);
        chk("pb_no_note", on_cnt + off_cnt, 0);
`endif

        // Reset in the middle of 90 3C, then a stray data byte
        clr();
        send(8'h90, 1); send(8'h3C, 1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t8_rst_note", {25'd0, m.note_num}, 32'h0);
        chk("t8_rst_vel", {25'd0, m.velocity}, 32'h0);
        rst = 1'b0;
        send(8'h64, 1); settle();
        chk("t8_no_events", on_cnt + off_cnt, 0);
        chk("t8_note_still0", {25'd0, m.note_num}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_msg_parser.md
Name: midi_msg_parser

Overview:
- Consumes the byte stream from the single-port MIDI UART receiver: `data_rx`, `is_command` and `new_byte_strobe`.
- Assembles complete channel-voice messages, with full running-status support.
- Emits one-cycle note-on and note-off events to the voice allocator.
- Consumes and discards all other message types. Real-time bytes are transparent and never disturb message assembly.

Parameters:
- RX_CHANNEL, 4'd0, channel accepted when omni is off (0 = MIDI channel 1).
- OMNI, 1'b1, 1 = accept all channels; 0 = accept only RX_CHANNEL.
- BYTE_W, 8, byte width, matching the receiver.

Ports:
- sys_clk  in  1  system clock, 48 MHz.
- sys_rst  in  1  asynchronous reset, active-high.
- data_rx  in  8  byte from the receiver.
- is_command  in  1  high when data_rx[7]=1 (status byte).
- new_byte_strobe  in  1  byte-valid level from the receiver. May stay high for several cycles per byte.
- note_on  out  1  one-cycle pulse: note-on with velocity > 0.
- note_off  out  1  one-cycle pulse: note-off, or note-on with velocity 0.
- channel  out  4  channel of the last emitted event.
- note_num  out  7  key number of the last emitted event.
- velocity  out  7  velocity of the last emitted event (release velocity for 8n).

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, state IDLE, running status cleared, strobe history 0.
- Byte acceptance:
  - Register new_byte_strobe into strobe_q.
  - A byte is accepted only in the cycle where new_byte_strobe=1 and strobe_q=0 (rising edge).
  - Exactly one acceptance per received byte, regardless of strobe width.
- Real-time bytes (F8–FF): ignored completely. No change to state, running status, or stored data.
- Status bytes 80–EF:
  - Store the status byte as running status.
  - Set expected length: 8n/9n/An/Bn/En = 2 data bytes; Cn/Dn = 1.
  - Go to WAIT_D1.
- Status bytes F0–F7: clear running status and go to SKIP. Data bytes are ignored until the next status byte 80–EF.
- State machine states: IDLE, WAIT_D1, WAIT_D2, SKIP.
  - IDLE: data bytes are ignored.
  - WAIT_D1, data byte: latch d1.
    - Length 1: message complete; go to WAIT_D1 (running status).
    - Length 2: go to WAIT_D2.
  - WAIT_D2, data byte: latch d2; message complete; go to WAIT_D1 (running status).
  - Any state, new status byte: abandon any partial message (no event) and apply the status rules above.
- Emit rule on message completion:
  - Applies only when the channel passes the filter (OMNI=1, or status[3:0]=RX_CHANNEL).
  - 9n with d2≠0 → note_on. 9n with d2=0 → note_off with velocity=0. 8n → note_off.
  - Other types: no event.
- Event timing:
  - Pulse and channel/note_num/velocity are registered together, one sys_clk after the accepting edge.
  - The pulse lasts exactly 1 cycle.
  - Data outputs hold their value until the next event.
- Data byte bit 7 is always 0 by construction. Store bits [6:0] only.
- Reset mid-message: partial message discarded. The first data byte after reset is ignored until a status byte arrives.

Optional Feature:
- PITCH_BEND_EN defined:
  - Adds outputs pitch_bend (14 bits, {d2,d1}, reset value 14'h2000) and pitch_bend_valid (one-cycle pulse).
  - Both are driven on completion of En on an accepted channel, with the same timing as note events.
- PITCH_BEND_EN undefined: ports absent; En is parsed and discarded.

Decomposition:
- Shared package midi_pkg:
  - Status nibble constants: NOTE_OFF=8, NOTE_ON=9, POLY_AT=A, CC=B, PROG=C, CH_AT=D, PITCH=E.
  - Real-time threshold constant 8'hF8.
  - State encoding for IDLE/WAIT_D1/WAIT_D2/SKIP.
- One natural sub-module: midi_status_len. Combinational lookup from status byte to data length (0/1/2) and a skip flag. It is reused by later CC/aftertouch decoders.

Test Plan:
- 90 3C 64 → note_on=1 for one cycle, channel=0, note_num=0x3C, velocity=0x64.
- Running status: 93 40 50 40 00 → note_on (ch3, 0x40, 0x50), then note_off (ch3, 0x40, vel 0).
- Real-time interleave: 90 3C F8 64 → single note_on, note 0x3C, vel 0x64. State unaffected by F8.
- Strobe held high 3 cycles per byte for 80 30 10 → exactly one note_off pulse.
- OMNI=0, RX_CHANNEL=1: 90 3C 64 → no event; then 91 3C 64 → note_on ch1.
- F0 7E 01 F7 3C 64 → no events. Then B0 07 7F → no event. Then sys_rst asserted mid 90 3C → outputs 0, no event after the subsequent 64.
